// File: rtl/dmem_port_arbiter.sv
// Shares one single-port synchronous-read data memory between the CPU data port and the VGA reader.
// Optional starvation guard for the VGA reader is enabled by defining DMEM_ARB_STARVE_EN.
module dmem_port_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_cpu_req,
    input  logic              i_cpu_wren,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic              o_cpu_gnt,
    output logic              o_cpu_rvalid,
    output logic [DATA_W-1:0] o_cpu_rdata,
    input  logic              i_vga_req,
    input  logic [ADDR_W-1:0] i_vga_addr,
    output logic              o_vga_gnt,
    output logic              o_vga_rvalid,
    output logic [DATA_W-1:0] o_vga_rdata,
    output logic [ADDR_W-1:0] o_mem_address,
    output logic [DATA_W-1:0] o_mem_data,
    output logic              o_mem_wren,
    input  logic [DATA_W-1:0] i_mem_q
);

    logic w_boost;
    logic w_cpu_gnt;
    logic w_vga_gnt;
    logic r_cpu_rd;
    logic r_vga_rd;

`ifdef DMEM_ARB_STARVE_EN
    localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);

    logic [7:0] r_wait_cnt;
    logic [7:0] w_wait_nxt;
    logic       r_boost;

    // VGA wait counter: cleared when VGA is idle or served, saturates at the limit.
    always_comb begin
        w_wait_nxt = r_wait_cnt;
        if (!i_vga_req || w_vga_gnt) begin
            w_wait_nxt = 8'd0;
        end else if (r_wait_cnt >= LP_MAX_WAIT) begin
            w_wait_nxt = LP_MAX_WAIT;
        end else begin
            w_wait_nxt = r_wait_cnt + 8'd1;
        end
    end

    // Boost is registered alongside the counter so grant stays a function of req and state only.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_wait_cnt <= 8'd0;
            r_boost    <= 1'b0;
        end else begin
            r_wait_cnt <= w_wait_nxt;
            r_boost    <= (w_wait_nxt == LP_MAX_WAIT);
        end
    end

    assign w_boost = r_boost;
`else
    assign w_boost = 1'b0;
`endif

    // Grant selection; no grant at all while reset is held.
    always_comb begin
        w_cpu_gnt = 1'b0;
        w_vga_gnt = 1'b0;
        if (i_reset) begin
            w_cpu_gnt = 1'b0;
            w_vga_gnt = 1'b0;
        end else if (w_boost) begin
            w_vga_gnt = i_vga_req;
            w_cpu_gnt = i_cpu_req & ~i_vga_req;
        end else begin
            w_cpu_gnt = i_cpu_req;
            w_vga_gnt = i_vga_req & ~i_cpu_req;
        end
    end

    assign o_cpu_gnt     = w_cpu_gnt;
    assign o_vga_gnt     = w_vga_gnt;
    assign o_mem_address = w_vga_gnt ? i_vga_addr : i_cpu_addr;
    assign o_mem_data    = i_cpu_wdata;
    assign o_mem_wren    = w_cpu_gnt & i_cpu_wren;

    // In-flight read tags: the RAM returns data one cycle after the grant edge.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_cpu_rd <= 1'b0;
            r_vga_rd <= 1'b0;
        end else begin
            r_cpu_rd <= w_cpu_gnt & ~i_cpu_wren;
            r_vga_rd <= w_vga_gnt;
        end
    end

    assign o_cpu_rvalid = r_cpu_rd;
    assign o_vga_rvalid = r_vga_rd;
    assign o_cpu_rdata  = i_mem_q;
    assign o_vga_rdata  = i_mem_q;

endmodule
